// File: rtl/note_scorer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : note_scorer_pkg
// Description : Shared note codes, judgment and state encodings, and the
//               streak multiplier helper for the note scorer.
// Revision    : 1.0 - initial release
// ============================================================================
package note_scorer_pkg;

  // Window note codes with special meaning
  localparam logic [3:0] NOTE_REST = 4'h0;
  localparam logic [3:0] NOTE_END  = 4'hF;

  // Largest value of (streak >> 3) that still raises the multiplier
  localparam int MULT_CAP = 3;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_HIT  = 2'd1,
    RES_MISS = 2'd2,
    RES_REST = 2'd3
  } result_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Points multiplier for a HIT given the streak before that HIT: 1..4
  function automatic logic [2:0] streak_mult(input logic [7:0] streak);
    logic [4:0] tier;
    tier = streak[7:3];
    if (tier > 5'(MULT_CAP)) begin
      return 3'(MULT_CAP + 1);
    end
    return 3'(tier) + 3'd1;
  endfunction

endpackage : note_scorer_pkg
`default_nettype wire

// File: rtl/scorer_accum.sv
`default_nettype none
// ============================================================================
// Module      : scorer_accum
// Description : Saturating score / streak / hit / miss bookkeeping. Applies
//               one judgment per strobe and publishes a registered result
//               with a one-cycle valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module scorer_accum
  import note_scorer_pkg::*;
#(
  parameter int SCORE_W     = 16,
  parameter int BASE_POINTS = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear_i,
  input  logic               judge_i,
  input  result_e            result_i,
  output logic [SCORE_W-1:0] score_o,
  output logic [7:0]         streak_o,
  output logic [7:0]         max_streak_o,
  output logic [7:0]         hits_o,
  output logic [7:0]         misses_o,
  output logic [1:0]         result_o,
  output logic               result_valid_o
);

  // Extra headroom so the addition can be checked for overflow
  localparam int SUM_W = SCORE_W + 8;
  localparam logic [SUM_W-1:0] SCORE_MAX = {8'd0, {SCORE_W{1'b1}}};

  logic [SCORE_W-1:0] score_q,  score_d;
  logic [7:0]         streak_q, streak_d;
  logic [7:0]         max_q,    max_d;
  logic [7:0]         hits_q,   hits_d;
  logic [7:0]         misses_q, misses_d;
  logic [1:0]         result_q;
  logic               valid_q;

  logic [2:0]         w_mult;
  logic [SUM_W-1:0]   w_points;
  logic [SUM_W-1:0]   w_sum;

  // Next statistics for the judgment being presented this cycle
  always_comb begin
    score_d  = score_q;
    streak_d = streak_q;
    max_d    = max_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    w_mult   = streak_mult(streak_q);
    w_points = SUM_W'(BASE_POINTS) * SUM_W'(w_mult);
    w_sum    = {8'd0, score_q} + w_points;
    case (result_i)
      RES_HIT: begin
        hits_d   = (hits_q == 8'hFF) ? hits_q : hits_q + 8'd1;
        streak_d = (streak_q == 8'hFF) ? streak_q : streak_q + 8'd1;
        if (streak_d > max_q) begin
          max_d = streak_d;
        end
        score_d  = (w_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
      end
      RES_MISS: begin
        misses_d = (misses_q == 8'hFF) ? misses_q : misses_q + 8'd1;
        streak_d = 8'd0;
      end
      default: begin
      end
    endcase
  end

  // Register statistics: cleared on start, updated on each judgment strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score_q  <= '0;
      streak_q <= '0;
      max_q    <= '0;
      hits_q   <= '0;
      misses_q <= '0;
      result_q <= RES_NONE;
      valid_q  <= 1'b0;
    end else if (clear_i) begin
      score_q  <= '0;
      streak_q <= '0;
      max_q    <= '0;
      hits_q   <= '0;
      misses_q <= '0;
      result_q <= RES_NONE;
      valid_q  <= 1'b0;
    end else if (judge_i) begin
      score_q  <= score_d;
      streak_q <= streak_d;
      max_q    <= max_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      result_q <= result_i;
      valid_q  <= 1'b1;
    end else begin
      valid_q  <= 1'b0;
    end
  end

  assign score_o        = score_q;
  assign streak_o       = streak_q;
  assign max_streak_o   = max_q;
  assign hits_o         = hits_q;
  assign misses_o       = misses_q;
  assign result_o       = result_q;
  assign result_valid_o = valid_q;

endmodule : scorer_accum
`default_nettype wire

// File: rtl/note_scorer.sv
`default_nettype none
// ============================================================================
// Module      : note_scorer
// Description : Judges each beat window of the loader's look-ahead as
//               HIT / MISS / REST from the pitch detector's note and keeps
//               score, streak and hit/miss statistics for display.
// Revision    : 1.0 - initial release
// ============================================================================
module note_scorer
  import note_scorer_pkg::*;
#(
  parameter int TEMPO_W     = 26,
  parameter int HIT_SHIFT   = 1,
  parameter int BASE_POINTS = 10,
  parameter int SCORE_W     = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               note_beat,
  input  logic [TEMPO_W-1:0] tempo,
  input  logic [63:0]        next_notes,
  input  logic [3:0]         played_note,
  input  logic               played_valid,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         streak,
  output logic [7:0]         max_streak,
  output logic [7:0]         hits,
  output logic [7:0]         misses,
  output logic [1:0]         result,
  output logic               result_valid,
  output logic               playing,
  output logic               song_done
);

  state_e             state_q;
  logic               armed_q;
  logic               playing_q;
  logic               done_q;
  logic [TEMPO_W-1:0] match_cnt_q, match_cnt_d;

  logic [3:0]         w_note;
  logic               w_match;
  logic [TEMPO_W:0]   w_total;
  logic [TEMPO_W-1:0] w_threshold;
  logic               w_judge;
  result_e            w_result;
  logic               w_unused_window;

  // Only the current slot matters here; later slots are for the display
  assign w_note          = next_notes[3:0];
  assign w_unused_window = ^next_notes[63:4];

  // Per-cycle match, running window total including this cycle, and verdict
  always_comb begin
    w_match     = (state_q == ST_PLAYING) && played_valid &&
                  (played_note == w_note) && (w_note != NOTE_REST);
    match_cnt_d = (&match_cnt_q) ? match_cnt_q : match_cnt_q + TEMPO_W'(1);
    w_total     = {1'b0, match_cnt_q} + (TEMPO_W + 1)'(w_match);
    w_threshold = tempo >> HIT_SHIFT;
    w_judge     = (state_q == ST_PLAYING) && note_beat && !start &&
                  armed_q && (w_note != NOTE_END);
    if (w_note == NOTE_REST) begin
      w_result = RES_REST;
    end else if (w_total >= {1'b0, w_threshold}) begin
      w_result = RES_HIT;
    end else begin
      w_result = RES_MISS;
    end
  end

  // Song FSM with arming of the first partial window and match counting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      armed_q     <= 1'b0;
      playing_q   <= 1'b0;
      done_q      <= 1'b0;
      match_cnt_q <= '0;
    end else if (start) begin
      state_q     <= ST_PLAYING;
      armed_q     <= 1'b0;
      playing_q   <= 1'b1;
      done_q      <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_PLAYING: begin
          if (note_beat) begin
            match_cnt_q <= '0;
            if (!armed_q) begin
              armed_q <= 1'b1;
            end else if (w_note == NOTE_END) begin
              state_q   <= ST_DONE;
              playing_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end else if (w_match) begin
            match_cnt_q <= match_cnt_d;
          end
        end
        default: begin
        end
      endcase
    end
  end

  scorer_accum #(
    .SCORE_W     (SCORE_W),
    .BASE_POINTS (BASE_POINTS)
  ) u_accum (
    .clk            (clk),
    .reset_n        (reset_n),
    .clear_i        (start),
    .judge_i        (w_judge),
    .result_i       (w_result),
    .score_o        (score),
    .streak_o       (streak),
    .max_streak_o   (max_streak),
    .hits_o         (hits),
    .misses_o       (misses),
    .result_o       (result),
    .result_valid_o (result_valid)
  );

  assign playing   = playing_q;
  assign song_done = done_q;

endmodule : note_scorer
`default_nettype wire

// File: tb/tb_note_scorer.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_scorer
// Description : Self-checking bench for note_scorer: directed song scenarios
//               plus random windows against a behavioural scoring model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_scorer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        note_beat;
  logic [25:0] tempo;
  logic [63:0] next_notes;
  logic [3:0]  played_note;
  logic        played_valid;
  logic [15:0] score;
  logic [7:0]  streak, max_streak, hits, misses;
  logic [1:0]  result;
  logic        result_valid, playing, song_done;

  int tests = 0;
  int fails = 0;

  // Behavioural model: song phase 0 idle / 1 playing / 2 done
  int m_phase, m_armed, m_window, m_score, m_streak, m_max, m_hits, m_misses;
  int m_result, m_rv;

  note_scorer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .note_beat    (note_beat),
    .tempo        (tempo),
    .next_notes   (next_notes),
    .played_note  (played_note),
    .played_valid (played_valid),
    .score        (score),
    .streak       (streak),
    .max_streak   (max_streak),
    .hits         (hits),
    .misses       (misses),
    .result       (result),
    .result_valid (result_valid),
    .playing      (playing),
    .song_done    (song_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_armed = 0; m_window = 0; m_score = 0; m_streak = 0; m_max = 0;
    m_hits = 0; m_misses = 0; m_result = 0; m_rv = 0;
  endtask

  // What a scorer should do at one clock edge given the inputs in force
  task automatic model_edge();
    int note, matched, total, mult;
    note    = int'(next_notes[3:0]);
    matched = (m_phase == 1 && played_valid && int'(played_note) == note && note != 0) ? 1 : 0;
    m_rv = 0;
    if (start) begin
      model_clear();
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (note_beat) begin
        total = m_window + matched;
        m_window = 0;
        if (m_armed == 0) begin
          m_armed = 1;
        end else if (note == 15) begin
          m_phase = 2;
        end else if (note == 0) begin
          m_result = 3; m_rv = 1;
        end else if (total >= int'(tempo) / 2) begin
          mult = 1 + ((m_streak / 8 < 3) ? m_streak / 8 : 3);
          m_score = m_score + 10 * mult;
          if (m_score > 65535) m_score = 65535;
          if (m_streak < 255) m_streak++;
          if (m_hits < 255) m_hits++;
          if (m_streak > m_max) m_max = m_streak;
          m_result = 1; m_rv = 1;
        end else begin
          m_streak = 0;
          if (m_misses < 255) m_misses++;
          m_result = 2; m_rv = 1;
        end
      end else begin
        m_window = m_window + matched;
      end
    end
  endtask

  task automatic check_all();
    chk("score",        32'(score),        32'(m_score));
    chk("streak",       32'(streak),       32'(m_streak));
    chk("max_streak",   32'(max_streak),   32'(m_max));
    chk("hits",         32'(hits),         32'(m_hits));
    chk("misses",       32'(misses),       32'(m_misses));
    chk("result",       32'(result),       32'(m_result));
    chk("result_valid", 32'(result_valid), 32'(m_rv));
    chk("playing",      32'(playing),      32'(m_phase == 1));
    chk("song_done",    32'(song_done),    32'(m_phase == 2));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_start(input logic with_beat);
    start = 1'b1; note_beat = with_beat;
    step();
    start = 1'b0; note_beat = 1'b0;
  endtask

  // One beat window: player matches the first nmatch cycles, beat on the last
  task automatic window(input int len, input logic [3:0] note, input int nmatch);
    for (int i = 0; i < len; i++) begin
      note_beat  = (i == len - 1);
      next_notes = {$urandom, $urandom};
      next_notes[3:0] = note;
      if (i < nmatch) begin
        played_valid = 1'b1; played_note = note;
      end else begin
        played_note  = 4'($urandom);
        played_valid = 1'($urandom);
        if (played_note == note) played_valid = 1'b0;
      end
      step();
    end
    note_beat = 1'b0;
  endtask

  initial begin
    int len, nm, nt;
    reset_n = 1'b0; start = 1'b0; note_beat = 1'b0; tempo = 26'd100;
    next_notes = '0; played_note = '0; played_valid = 1'b0;
    m_phase = 0; model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    reset_n = 1'b1;
    step();

    // Four beats at tempo 100, note 5 held and matched throughout
    do_start(1'b0);
    window(100, 4'd5, 100);
    chk("first_beat_unjudged_rv", 32'(result_valid), 32'd0);
    for (int b = 0; b < 3; b++) begin
      window(100, 4'd5, 100);
      chk("hit_rv", 32'(result_valid), 32'd1);
      chk("hit_result", 32'(result), 32'd1);
    end
    chk("score_after_3_hits", 32'(score), 32'd30);
    chk("streak_after_3_hits", 32'(streak), 32'd3);
    chk("hits_after_3_hits", 32'(hits), 32'd3);

    // Threshold edge: 49 matched cycles miss, 50 hit
    window(100, 4'd5, 49);
    chk("miss_at_49", 32'(result), 32'd2);
    chk("miss_clears_streak", 32'(streak), 32'd0);
    window(100, 4'd5, 50);
    chk("hit_at_50", 32'(result), 32'd1);
    chk("streak_after_50", 32'(streak), 32'd1);

    // Nine straight hits: multiplier steps up on the ninth
    tempo = 26'd4;
    do_start(1'b0);
    window(4, 4'd5, 4);
    for (int b = 0; b < 9; b++) window(4, 4'd7, 4);
    chk("score_after_9_hits", 32'(score), 32'd100);
    chk("max_streak_9", 32'(max_streak), 32'd9);

    // Rest window with the player sounding throughout
    window(4, 4'd0, 4);
    chk("rest_result", 32'(result), 32'd3);
    chk("rest_streak_held", 32'(streak), 32'd9);
    window(4, 4'd6, 2);
    chk("after_rest_hit", 32'(result), 32'd1);

    // Random windows, including back-to-back single-cycle beats
    for (int w = 0; w < 80; w++) begin
      len = $urandom_range(1, 12);
      nm  = $urandom_range(0, len);
      nt  = $urandom_range(0, 14);
      tempo = 26'($urandom_range(1, 16));
      window(len, 4'(nt), nm);
    end

    // End of song, then ignored beats, then restart
    window(4, 4'hF, 0);
    chk("end_done", 32'(song_done), 32'd1);
    chk("end_not_playing", 32'(playing), 32'd0);
    chk("end_no_rv", 32'(result_valid), 32'd0);
    window(4, 4'd5, 4);
    window(4, 4'd5, 0);
    do_start(1'b0);
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_playing", 32'(playing), 32'd1);

    // Short asynchronous reset mid-song
    tempo = 26'd4;
    window(4, 4'd5, 4);
    window(4, 4'd5, 4);
    window(4, 4'd5, 4);
    #2 reset_n = 1'b0;
    #1;
    m_phase = 0; model_clear();
    chk("async_score", 32'(score), 32'd0);
    chk("async_playing", 32'(playing), 32'd0);
    check_all();
    #2 reset_n = 1'b1;
    step();

    // Start coincident with a beat
    do_start(1'b0);
    window(4, 4'd5, 4);
    window(4, 4'd5, 4);
    next_notes = 64'd5; played_note = 4'd5; played_valid = 1'b1;
    do_start(1'b1);
    chk("start_beat_rv", 32'(result_valid), 32'd0);
    chk("start_beat_hits", 32'(hits), 32'd0);
    window(4, 4'd5, 4);
    chk("unarmed_after_start", 32'(hits), 32'd0);
    window(4, 4'd5, 4);
    chk("armed_hit", 32'(hits), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_note_scorer
`default_nettype wire
